// File: rtl/adder_seq_pkg.sv
// ----------------------------------------------------------------------------
// adder_seq_pkg
// Shared definitions for the sequential multi-byte adder:
//   state_t         controller states (IDLE, RUN, DONE)
//   BYTE_W          width of one adder slice
//   NBYTES_DEFAULT  default number of slices per operand
// ----------------------------------------------------------------------------
package adder_seq_pkg;

   localparam int BYTE_W         = 8;
   localparam int NBYTES_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : adder_seq_pkg

// File: rtl/hybridadder8_struct.sv
// ----------------------------------------------------------------------------
// hybridadder8_struct
// Combinational 8-bit adder built from three segments:
//   bits 1:0  ripple-carry
//   bits 5:2  4-bit carry-lookahead (carries formed from generate/propagate
//             terms directly off c[2], so the middle segment adds no ripple)
//   bits 7:6  ripple-carry
// Ports:
//   x, y  [7:0]  addends
//   c0           carry-in
//   s     [7:0]  sum
//   c8           carry-out of bit 7
// ----------------------------------------------------------------------------
module hybridadder8_struct
   import adder_seq_pkg::*;
(
   input  logic [BYTE_W-1:0] x,
   input  logic [BYTE_W-1:0] y,
   input  logic              c0,
   output logic [BYTE_W-1:0] s,
   output logic              c8
);

   logic [BYTE_W-1:0] g;
   logic [BYTE_W-1:0] p;
   logic [BYTE_W:0]   c;

   assign g = x & y;
   assign p = x ^ y;

   // Low ripple segment.
   assign c[0] = c0;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & c[1]);

   // Lookahead segment: every carry depends only on c[2] and local g/p.
   assign c[3] = g[2] | (p[2] & c[2]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & c[2]);
   assign c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
               | (p[4] & p[3] & p[2] & c[2]);
   assign c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & g[3])
               | (p[5] & p[4] & p[3] & g[2])
               | (p[5] & p[4] & p[3] & p[2] & c[2]);

   // High ripple segment.
   assign c[7] = g[6] | (p[6] & c[6]);
   assign c[8] = g[7] | (p[7] & c[7]);

   assign s  = p ^ c[BYTE_W-1:0];
   assign c8 = c[BYTE_W];

endmodule : hybridadder8_struct

// File: rtl/multibyte_adder_seq.sv
// ----------------------------------------------------------------------------
// multibyte_adder_seq
// Adds two NBYTES-wide unsigned operands by stepping a single 8-bit hybrid
// adder across the bytes, LSB first, chaining each byte's carry-out into the
// next byte's carry-in. One byte is processed per clock.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair on a/b/cin is valid
//   in_ready   operands accepted (high only in IDLE)
//   a, b       [8*NBYTES-1:0] addends
//   cin        carry-in to byte 0
//   out_valid  sum/cout valid (DONE)
//   out_ready  consumer accepts the result
//   sum        [8*NBYTES-1:0] a+b+cin modulo 2^(8*NBYTES)
//   cout       carry-out of the top byte
//   busy       high in RUN or DONE
// ----------------------------------------------------------------------------
module multibyte_adder_seq
   import adder_seq_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BYTE_W*NBYTES-1:0] a,
   input  logic [BYTE_W*NBYTES-1:0] b,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BYTE_W*NBYTES-1:0] sum,
   output logic                     cout,
   output logic                     busy
);

   localparam int W     = BYTE_W * NBYTES;
   localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_t            state;
   logic [IDX_W-1:0]  idx;
   logic              carry_reg;
   logic [W-1:0]      a_reg;
   logic [W-1:0]      b_reg;

   logic [BYTE_W-1:0] x_byte;
   logic [BYTE_W-1:0] y_byte;
   logic [BYTE_W-1:0] s_byte;
   logic              c8;

   // Byte slice currently presented to the adder.
   assign x_byte = a_reg[idx*BYTE_W +: BYTE_W];
   assign y_byte = b_reg[idx*BYTE_W +: BYTE_W];

   hybridadder8_struct u_add8 (
      .x  (x_byte),
      .y  (y_byte),
      .c0 (carry_reg),
      .s  (s_byte),
      .c8 (c8)
   );

   // Handshake/status flags are decoded straight from the state register,
   // so they are glitch-free and valid from the first cycle after reset.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   // NOTE: a_reg/b_reg are left out of reset on purpose; they are always
   // loaded on acceptance before the adder ever reads them.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         carry_reg <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples
         // pre-edge values regardless of statement order.
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg     <= a;
                  b_reg     <= b;
                  carry_reg <= cin;
                  idx       <= '0;
                  sum       <= '0;
                  state     <= RUN;
               end
            end

            RUN: begin
               sum[idx*BYTE_W +: BYTE_W] <= s_byte;
               carry_reg                 <= c8;
               if (idx == LAST_IDX) begin
                  // Counter is cleared rather than incremented so it never
                  // wraps for power-of-two NBYTES.
                  idx   <= '0;
                  cout  <= c8;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule : multibyte_adder_seq
